// File: rtl/aligned_ram_pkg.sv
// -----------------------------------------------------------------------------
// aligned_ram_pkg
// Shared types and constants for the aligned_ram store target.
//   DATA_W      : data word width (fixed at 32)
//   BYTE_OFF_W  : byte-offset bits within a word (2 -> 4-byte granule)
//   word_t      : one data word / one byte address
//   is_aligned  : true when a byte address falls on a word boundary
// -----------------------------------------------------------------------------
package aligned_ram_pkg;

  localparam int DATA_W     = 32;
  localparam int BYTE_OFF_W = 2;
  localparam int WORD_BYTES = DATA_W / 8;

  typedef logic [31:0] word_t;

  // Masking the full address keeps every bit referenced; only the
  // byte-offset bits can survive the mask.
  function automatic logic is_aligned(input word_t addr);
    return (addr & word_t'(WORD_BYTES - 1)) == '0;
  endfunction

endpackage

// File: rtl/aligned_addr_check.sv
// -----------------------------------------------------------------------------
// aligned_addr_check
// Purely combinational decode of a byte address into a word index plus
// legality flags for the aligned_ram write port.
// Parameters:
//   DEPTH         number of 32-bit words (power of two, >= 2)
// Ports:
//   addr          in   32            byte address of the request
//   legal         out  1             aligned and in range
//   misaligned    out  1             addr[1:0] != 0
//   out_of_range  out  1             word address >= DEPTH
//   idx           out  $clog2(DEPTH) word index addr[$clog2(DEPTH)+1:2]
// -----------------------------------------------------------------------------
module aligned_addr_check
  import aligned_ram_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  word_t                      addr,
  output logic                       legal,
  output logic                       misaligned,
  output logic                       out_of_range,
  output logic [$clog2(DEPTH)-1:0]   idx
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31-BYTE_OFF_W:0] DEPTH_WORDS = (32-BYTE_OFF_W)'(DEPTH);

  // Compare the whole word address, not just the index bits, so that any
  // high address bit set is caught rather than aliasing onto a low word.
  assign misaligned   = !is_aligned(addr);
  assign out_of_range = addr[31:BYTE_OFF_W] >= DEPTH_WORDS;
  assign legal        = !misaligned && !out_of_range;
  assign idx          = addr[AW+BYTE_OFF_W-1:BYTE_OFF_W];

endmodule

// File: rtl/aligned_ram.sv
// -----------------------------------------------------------------------------
// aligned_ram
// Word-addressed 32-bit write-only RAM taking a byte address. Only writes to
// 4-byte-aligned, in-range addresses update the array; any other write
// attempt raises a registered error flag one cycle later. Contents are read
// out by hierarchical reference to the internal array `mem`.
// Parameters:
//   DEPTH   number of 32-bit words (power of two, >= 2)
// Ports:
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset (clears error and mem)
//   wr_en   in   1   write request
//   addr    in   32  byte address of the write
//   wdata   in   32  write data
//   error   out  1   registered illegal-write flag
// Configuration:
//   ALIGNED_RAM_STICKY_ERR_EN  when defined, error stays set after the first
//                              illegal write until reset; otherwise error is
//                              a per-request pulse.
// -----------------------------------------------------------------------------
module aligned_ram
  import aligned_ram_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  word_t addr,
  input  word_t wdata,
  output logic  error
);

  localparam int AW = $clog2(DEPTH);

  word_t mem [DEPTH];

  logic          w_legal;
  logic          w_misaligned;
  logic          w_out_of_range;
  logic [AW-1:0] w_idx;
  logic          w_bad_req;
  logic          r_error;

  aligned_addr_check #(
    .DEPTH (DEPTH)
  ) u_addr_check (
    .addr         (addr),
    .legal        (w_legal),
    .misaligned   (w_misaligned),
    .out_of_range (w_out_of_range),
    .idx          (w_idx)
  );

  // Either fault on an actual request is reported; idle cycles never are.
  assign w_bad_req = wr_en && (w_misaligned || w_out_of_range);

  // NOTE: the array is cleared by the asynchronous reset, so it is built from
  // resettable flops rather than a RAM macro; a block RAM cannot be zeroed
  // in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && w_legal) begin
      mem[w_idx] <= wdata;
    end
  end

  // NOTE: state is assigned with <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= 1'b0;
    end else begin
`ifdef ALIGNED_RAM_STICKY_ERR_EN
      r_error <= r_error || w_bad_req;
`else
      r_error <= w_bad_req;
`endif
    end
  end

  assign error = r_error;

endmodule

// File: tb/tb_aligned_ram.sv
// -----------------------------------------------------------------------------
// tb_aligned_ram
// Self-checking bench for aligned_ram. Each driven request pushes its
// expected error value to a scoreboard queue; the entry is popped and
// compared once the DUT has taken the clock edge. Array contents are
// compared against a reference model through hierarchical access.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aligned_ram;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        error;

  aligned_ram #(
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .addr  (addr),
    .wdata (wdata),
    .error (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_errors;
  logic [31:0] model_mem [DEPTH];
  logic        model_err;
  logic        exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic req_illegal(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

  // Number of array words that differ from the reference model.
  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dut.mem[i] !== model_mem[i]) n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_err = 1'b0;
    exp_q.delete();
  endtask

  // One request: drive on the falling edge, predict, then compare just after
  // the rising edge that samples it.
  task automatic do_cycle(input string tag, input logic we, input logic [31:0] a,
                          input logic [31:0] d);
    logic        bad;
    logic        exp_err;
    logic [AW-1:0] wi;
    @(negedge clk);
    wr_en = we;
    addr  = a;
    wdata = d;
    bad   = we && req_illegal(a);
    wi    = a[AW+1:2];
`ifdef ALIGNED_RAM_STICKY_ERR_EN
    model_err = model_err || bad;
`else
    model_err = bad;
`endif
    exp_q.push_back(model_err);
    if (we && !bad) model_mem[wi] = d;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_err = exp_q.pop_front();
      check({tag, "_err"}, {31'd0, error}, {31'd0, exp_err});
    end
    check({tag, "_mem"}, dut.mem[wi], model_mem[wi]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    wr_en    = 1'b0;
    addr     = '0;
    wdata    = '0;
    rst_n    = 1'b0;
    model_reset();

    // Reset sweep: a write presented during reset must be discarded.
    wr_en = 1'b1;
    addr  = 32'h0000_000C;
    wdata = 32'hFFFF_FFFF;
    #11;
    check("rst_err_low", {31'd0, error}, 32'd0);
    check("rst_mem_zero", 32'(mem_diffs()), 32'd0);
    wr_en = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_mem_zero", 32'(mem_diffs()), 32'd0);
    check("post_rst_err", {31'd0, error}, 32'd0);

    // Directed cases.
    do_cycle("aligned_w1",   1'b1, 32'h0000_0004, 32'h0000_0008);
    do_cycle("misalign_5",   1'b1, 32'h0000_0005, 32'h0000_0012);
    do_cycle("idle_8",       1'b0, 32'h0000_0008, 32'h0000_0010);
    do_cycle("oor_400",      1'b1, 32'h0000_0400, 32'hAAAA_5555);
    check("oor_no_change", 32'(mem_diffs()), 32'd0);
    do_cycle("b2b_oor_402",  1'b1, 32'h0000_0402, 32'h1234_5678);
    do_cycle("b2b_mis_7",    1'b1, 32'h0000_0007, 32'h1357_9BDF);
    do_cycle("last_3fc",     1'b1, 32'h0000_03FC, 32'hCAFE_F00D);
    do_cycle("first_0",      1'b1, 32'h0000_0000, 32'h0BAD_F00D);
    do_cycle("mis_1",        1'b1, 32'h0000_0001, 32'h1111_1111);
    do_cycle("mis_2",        1'b1, 32'h0000_0002, 32'h2222_2222);
    do_cycle("mis_3",        1'b1, 32'h0000_0003, 32'h3333_3333);
    do_cycle("legal_after",  1'b1, 32'h0000_0008, 32'h4444_4444);
    do_cycle("hi_bit_alias", 1'b1, 32'h8000_0004, 32'h5555_5555);
    do_cycle("top_addr",     1'b1, 32'hFFFF_FFFC, 32'h6666_6666);
    do_cycle("idle_after",   1'b0, 32'hFFFF_FFFF, 32'h7777_7777);
    check("directed_mem", 32'(mem_diffs()), 32'd0);

    // Random mix of legal, misaligned, out-of-range and idle requests.
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      logic        we;
      a  = $urandom_range(0, 4 * DEPTH + 32);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      we = ($urandom_range(0, 4) != 0);
      do_cycle("rand", we, a, $urandom());
    end
    check("random_mem", 32'(mem_diffs()), 32'd0);

    // Mid-operation reset: error cleared at once, in-flight write lost.
    do_cycle("pre_rst_w4",  1'b1, 32'h0000_0010, 32'h0000_1111);
    do_cycle("pre_rst_bad", 1'b1, 32'h0000_0011, 32'h0000_2222);
    @(negedge clk);
    wr_en = 1'b1;
    addr  = 32'h0000_0014;
    wdata = 32'hDEAD_BEEF;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_err", {31'd0, error}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_write_lost", dut.mem[5], 32'd0);
    check("rst_mem_cleared", 32'(mem_diffs()), 32'd0);
    check("rst_err_held", {31'd0, error}, 32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;

    do_cycle("post_rst_bad",   1'b1, 32'h0000_0006, 32'h0000_3333);
    do_cycle("post_rst_legal", 1'b1, 32'h0000_0018, 32'h0000_4444);
    do_cycle("post_rst_idle",  1'b0, 32'h0000_0000, 32'h0000_0000);
    check("final_mem", 32'(mem_diffs()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
